// File: rtl/ifetch_pipe.sv
// ifetch_pipe: instruction fetch stage.
// Holds the PC, issues single-outstanding requests to a variable-latency
// instruction memory, buffers responses in a small prefetch FIFO and drives
// a stallable, flushable IF/ID register. A redirect from EX/MEM flushes the
// FIFO and IF/ID and drops any response still in flight.
// Optional performance counters are enabled with the IFETCH_PERF_EN macro.
module ifetch_pipe #(
    parameter int unsigned          ADDR_W     = 32,
    parameter int unsigned          DATA_W     = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC   = '0,
    parameter int unsigned          PC_STEP    = 1,
    parameter int unsigned          FIFO_DEPTH = 2,
    parameter logic [DATA_W-1:0]    NOP_INSTR  = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_mem_pcsrc,
    input  logic [ADDR_W-1:0] ex_mem_npc,
    input  logic              id_stall,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0] if_id_npc,
    output logic              if_id_valid
`ifdef IFETCH_PERF_EN
   ,output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_redirect_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);
    localparam logic [CNT_W:0] ONE_C   = (CNT_W+1)'(1);

    typedef enum logic [1:0] {
        ST_REQ     = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   fifo_instr_q [FIFO_DEPTH];
    logic [ADDR_W-1:0]   fifo_npc_q   [FIFO_DEPTH];
    logic [DATA_W-1:0]   if_id_instr_q, if_id_instr_d;
    logic [ADDR_W-1:0]   if_id_npc_q, if_id_npc_d;
    logic                if_id_valid_q, if_id_valid_d;

    logic [ADDR_W-1:0]   pc_inc_s;
    logic [CNT_W:0]      occ_s;
    logic [CNT_W:0]      cnt_p1_s;
    logic                fifo_empty_s;
    logic                push_s;
    logic                pop_s;
    logic                req_s;
    logic [ADDR_W-1:0]   addr_s;

    assign pc_inc_s     = pc_q + ADDR_W'(PC_STEP);
    // Occupancy counts buffered entries plus the one response still owed.
    assign occ_s        = {1'b0, cnt_q} + {{CNT_W{1'b0}}, (state_q == ST_WAIT)};
    assign cnt_p1_s     = {1'b0, cnt_q} + ONE_C;
    assign fifo_empty_s = (cnt_q == '0);

    // Fetch FSM next state, PC update, request generation and FIFO push.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push_s  = 1'b0;
        req_s   = 1'b0;
        addr_s  = pc_q;
        if (ex_mem_pcsrc) begin
            pc_d = ex_mem_npc;
            case (state_q)
                ST_WAIT:    state_d = imem_rvalid ? ST_REQ : ST_DISCARD;
                ST_DISCARD: state_d = imem_rvalid ? ST_REQ : ST_DISCARD;
                default:    state_d = ST_REQ;
            endcase
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (occ_s < DEPTH_C) begin
                        req_s   = 1'b1;
                        addr_s  = pc_q;
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        push_s = 1'b1;
                        pc_d   = pc_inc_s;
                        // A same-cycle pop does not free space for this request.
                        if (cnt_p1_s < DEPTH_C) begin
                            req_s   = 1'b1;
                            addr_s  = pc_inc_s;
                            state_d = ST_WAIT;
                        end else begin
                            state_d = ST_REQ;
                        end
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_DISCARD: begin
                    if (imem_rvalid) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_DISCARD;
                    end
                end
                default: state_d = ST_REQ;
            endcase
        end
    end

    assign imem_req  = req_s & rst_n;
    assign imem_addr = addr_s;

    assign pop_s = ~fifo_empty_s & (~id_stall | ~if_id_valid_q) & ~ex_mem_pcsrc;

    // IF/ID next value: flush on redirect, load FIFO head, or drain/hold.
    always_comb begin
        if_id_valid_d = if_id_valid_q;
        if_id_instr_d = if_id_instr_q;
        if_id_npc_d   = if_id_npc_q;
        if (ex_mem_pcsrc) begin
            if_id_valid_d = 1'b0;
            if_id_instr_d = NOP_INSTR;
        end else if (pop_s) begin
            if_id_valid_d = 1'b1;
            if_id_instr_d = fifo_instr_q[rd_ptr_q];
            if_id_npc_d   = fifo_npc_q[rd_ptr_q];
        end else if (!id_stall) begin
            if_id_valid_d = 1'b0;
        end else begin
            if_id_valid_d = if_id_valid_q;
        end
    end

    // State, PC and IF/ID registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_REQ;
            pc_q          <= RESET_PC;
            if_id_valid_q <= 1'b0;
            if_id_instr_q <= NOP_INSTR;
            if_id_npc_q   <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_id_valid_q <= if_id_valid_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_npc_q   <= if_id_npc_d;
        end
    end

    // Prefetch FIFO storage, pointers and count; redirect empties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_instr_q[i] <= '0;
                fifo_npc_q[i]   <= '0;
            end
        end else if (ex_mem_pcsrc) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_s) begin
                fifo_instr_q[wr_ptr_q] <= imem_rdata;
                fifo_npc_q[wr_ptr_q]   <= pc_inc_s;
                wr_ptr_q               <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign if_id_instr = if_id_instr_q;
    assign if_id_npc   = if_id_npc_q;
    assign if_id_valid = if_id_valid_q;

`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch_q, perf_redirect_q, perf_stall_q;

    // Saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_q    <= 32'h0000_0000;
            perf_redirect_q <= 32'h0000_0000;
            perf_stall_q    <= 32'h0000_0000;
        end else begin
            if (push_s && (perf_fetch_q != 32'hFFFF_FFFF)) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
            if (ex_mem_pcsrc && (perf_redirect_q != 32'hFFFF_FFFF)) begin
                perf_redirect_q <= perf_redirect_q + 32'd1;
            end
            if (id_stall && if_id_valid_q && (perf_stall_q != 32'hFFFF_FFFF)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt    = perf_fetch_q;
    assign perf_redirect_cnt = perf_redirect_q;
    assign perf_stall_cnt    = perf_stall_q;
`endif

endmodule
